// File: rtl/seq_multiplier_32bit.sv
// Unsigned shift-add multiplier: one conditional add and right shift per clock,
// WIDTH steps per operation, result held until the next accepted start.
module seq_multiplier_32bit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;
    logic             last_step;
    logic [WIDTH:0]   sum;

    assign last_step = (count == CW'(WIDTH - 1));

    // Upper-half add keeps its carry so the shift can bring it into the MSB.
    assign sum = {1'b0, product[2*WIDTH-1:WIDTH]}
               + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand   <= a;
                        mplier  <= b;
                        product <= '0;
                        count   <= '0;
                    end
                end
                RUN: begin
                    product <= {sum, product[WIDTH-1:1]};
                    mplier  <= mplier >> 1;
                    count   <= count + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Directed self-checking bench for seq_multiplier_32bit.
module tb_seq_multiplier_32bit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] product;
    logic        busy;
    logic        done;

    int passed;
    int total;

    seq_multiplier_32bit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start an op, scramble the inputs after acceptance, wait (bounded) for done.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          output int lat, output int busy_cycles,
                          output logic [63:0] prod);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        lat         = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cycles++;
            tick();
            lat++;
        end
        prod = product;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        a     = 32'd3;
        b     = 32'd5;
        tick();
        tick();
        total++;
        if (product !== 64'd0) $display("FAIL reset_product: got %h want %h", product, 64'd0);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else passed++;
        total++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done);
        else passed++;
        start = 1'b0;
        reset = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) $display("FAIL reset_no_start: busy got %b want 0", busy);
        else passed++;
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [63:0] p;
        run_op(32'h3, 32'h5, lat, bc, p);
        total++;
        if (lat !== 32) $display("FAIL basic_latency: got %0d want 32", lat);
        else passed++;
        total++;
        if (bc !== 32) $display("FAIL basic_busy_cycles: got %0d want 32", bc);
        else passed++;
        total++;
        if (p !== 64'h000000000000000F) $display("FAIL basic_product: got %h want %h", p, 64'h000000000000000F);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b want 0", busy);
        else passed++;
        tick();
        total++;
        if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done);
        else passed++;
        total++;
        if (product !== 64'h000000000000000F) $display("FAIL basic_hold: got %h want %h", product, 64'h000000000000000F);
        else passed++;
    endtask

    task automatic test_max_operands();
        int lat, bc;
        logic [63:0] p;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, p);
        total++;
        if (p !== 64'hFFFFFFFE00000001) $display("FAIL max_product: got %h want %h", p, 64'hFFFFFFFE00000001);
        else passed++;
        tick();
        run_op(32'h05453FAF, 32'h00000001, lat, bc, p);
        total++;
        if (p !== 64'h0000000005453FAF) $display("FAIL ident_product: got %h want %h", p, 64'h0000000005453FAF);
        else passed++;
        tick();
        run_op(32'h0001_0000, 32'h0001_0000, lat, bc, p);
        total++;
        if (p !== 64'h0000000100000000) $display("FAIL pow2_product: got %h want %h", p, 64'h0000000100000000);
        else passed++;
        tick();
    endtask

    task automatic test_zero();
        int lat, bc;
        logic [63:0] p;
        run_op(32'h0, 32'hFFFFFFFF, lat, bc, p);
        total++;
        if (p !== 64'd0) $display("FAIL zero_product: got %h want %h", p, 64'd0);
        else passed++;
        total++;
        if (lat !== 32) $display("FAIL zero_latency: got %0d want 32", lat);
        else passed++;
        tick();
    endtask

    task automatic test_start_while_busy();
        int done_count;
        a     = 32'd7;
        b     = 32'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_count = 0;
        for (int i = 0; i < 5; i++) tick();
        a     = 32'd2;
        b     = 32'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                done_count++;
                total++;
                if (product !== 64'd63) $display("FAIL busy_start_product: got %h want %h", product, 64'd63);
                else passed++;
                // Request during the done cycle must also be ignored.
                start = 1'b1;
                tick();
                start = 1'b0;
                total++;
                if (busy !== 1'b0) $display("FAIL done_start_ignored: busy got %b want 0", busy);
                else passed++;
            end else begin
                tick();
            end
        end
        total++;
        if (done_count !== 1) $display("FAIL busy_start_done_count: got %0d want 1", done_count);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        int done_count;
        int lat, bc;
        logic [63:0] p;
        a     = 32'd3;
        b     = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy);
        else passed++;
        total++;
        if (product !== 64'd0) $display("FAIL midreset_product: got %h want %h", product, 64'd0);
        else passed++;
        done_count = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_count++;
            tick();
        end
        total++;
        if (done_count !== 0) $display("FAIL midreset_no_done: got %0d want 0", done_count);
        else passed++;
        run_op(32'd1, 32'd1, lat, bc, p);
        total++;
        if (p !== 64'd1) $display("FAIL midreset_restart_product: got %h want %h", p, 64'd1);
        else passed++;
        total++;
        if (lat !== 32) $display("FAIL midreset_restart_latency: got %0d want 32", lat);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        test_reset();
        test_basic();
        test_max_operands();
        test_zero();
        test_start_while_busy();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
